// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
package piso_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: clears on load, steps on advance, flags the last frame bit.
module piso_bit_counter #(
  parameter int unsigned LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic advance,
  output logic last_c
);

  localparam int unsigned CW = $clog2(LEN);

  logic [CW-1:0] cnt;

  // Index of the bit currently on sout; load has priority over advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last_c = (cnt == CW'(LEN - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready on both sides.
// Optional macro PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             frame_done
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif

  state_e               state;
  state_e               state_nxt;
  logic [FRAME_LEN-1:0] sreg;
  logic [FRAME_LEN-1:0] sreg_nxt;
  logic [FRAME_LEN-1:0] frame_c;
  logic                 sout_nxt;
  logic                 sout_valid_nxt;
  logic                 frame_done_nxt;
  logic                 cnt_load;
  logic                 cnt_advance;
  logic                 last_c;
  logic                 accept_c;
  logic                 consume_c;

  // Word laid out in transmission order: head bit is the first one sent
`ifdef PISO_PARITY_EN
  assign frame_c = MSB_FIRST ? {in_data, ^in_data} : {^in_data, in_data};
`else
  assign frame_c = in_data;
`endif

  piso_bit_counter #(
    .LEN (FRAME_LEN)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .advance (cnt_advance),
    .last_c  (last_c)
  );

  // Ready when idle, or when the last bit leaves this cycle (back-to-back)
  assign in_ready  = (state == IDLE) || ((state == SHIFT) && last_c && sout_ready);
  assign accept_c  = in_valid && in_ready;
  assign consume_c = (state == SHIFT) && sout_ready;

  // State, shift register and registered serial outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sreg       <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      sout       <= sout_nxt;
      sout_valid <= sout_valid_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Next state, shift register update and counter control
  always_comb begin
    state_nxt      = state;
    sreg_nxt       = sreg;
    cnt_load       = 1'b0;
    cnt_advance    = 1'b0;
    frame_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (accept_c) begin
          state_nxt = SHIFT;
          sreg_nxt  = frame_c;
          cnt_load  = 1'b1;
        end
      end
      SHIFT: begin
        if (consume_c) begin
          if (last_c) begin
            frame_done_nxt = 1'b1;
            cnt_load       = 1'b1;
            if (accept_c) begin
              sreg_nxt = frame_c;
            end else begin
              state_nxt = IDLE;
              sreg_nxt  = '0;
            end
          end else begin
            cnt_advance = 1'b1;
            sreg_nxt    = MSB_FIRST ? {sreg[FRAME_LEN-2:0], 1'b0}
                                    : {1'b0, sreg[FRAME_LEN-1:1]};
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    sout_valid_nxt = (state_nxt == SHIFT);
    sout_nxt       = MSB_FIRST ? sreg_nxt[FRAME_LEN-1] : sreg_nxt[0];
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus,
// a frame-level model is checked every cycle, plus hand-computed vectors.
module tb_piso_serializer;

  localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic [W-1:0] in_data    = '0;
  logic         in_valid   = 1'b0;
  logic         sout_ready = 1'b0;

  logic in_ready_m, sout_m, sout_valid_m, frame_done_m;
  logic in_ready_l, sout_l, sout_valid_l, frame_done_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready_m),
    .sout       (sout_m),
    .sout_valid (sout_valid_m),
    .sout_ready (sout_ready),
    .frame_done (frame_done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready_l),
    .sout       (sout_l),
    .sout_valid (sout_valid_l),
    .sout_ready (sout_ready),
    .frame_done (frame_done_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: active word plus index k of the bit on the line
  bit           m_active = 1'b0;
  logic [W-1:0] m_word   = '0;
  int           m_k      = 0;
  bit           m_done   = 1'b0;
  bit           m_acc;
  bit           m_cons;

  // Bit k of the frame for the given order; k == W is the even-parity bit
  function automatic logic exp_bit(input logic [W-1:0] w, input int k, input bit msb);
    logic [W-1:0] t;
    int           idx;
    if (k >= int'(W)) return ^w;
    idx = msb ? (int'(W) - 1 - k) : k;
    t   = w >> idx;
    return t[0];
  endfunction

  function automatic bit m_ready();
    return !m_active || ((m_k == int'(FL) - 1) && (sout_ready == 1'b1));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_word   = '0;
      m_k      = 0;
      m_done   = 1'b0;
    end else begin
      m_acc  = (in_valid == 1'b1) && m_ready();
      m_cons = m_active && (sout_ready == 1'b1);
      m_done = m_cons && (m_k == int'(FL) - 1);
      if (m_cons) begin
        if (m_done) m_active = 1'b0;
        else        m_k      = m_k + 1;
      end
      if (m_acc) begin
        m_active = 1'b1;
        m_word   = in_data;
        m_k      = 0;
      end
    end
  end

  // Every cycle out of reset, both instances against the model
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("m_valid",    sout_valid_m, m_active);
      chk("m_sout",     sout_m,       m_active ? exp_bit(m_word, m_k, 1'b1) : 1'b0);
      chk("m_done",     frame_done_m, m_done);
      chk("m_in_ready", in_ready_m,   m_ready());
      chk("l_valid",    sout_valid_l, m_active);
      chk("l_sout",     sout_l,       m_active ? exp_bit(m_word, m_k, 1'b0) : 1'b0);
      chk("l_done",     frame_done_l, m_done);
      chk("l_in_ready", in_ready_l,   m_ready());
    end
  end

  // Present a word while idle; returns at the negedge of cycle 1 after accept
  task automatic send(input logic [W-1:0] d);
    chk("send_in_ready", in_ready_m, 1);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  task automatic drain();
    int n = 0;
    while (sout_valid_m === 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", sout_valid_m, 0);
    @(negedge clk);
  endtask

  bit seq_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  bit seq_3c [8] = '{0, 0, 1, 1, 1, 1, 0, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sout",       sout_m,       0);
    chk("rst_valid",      sout_valid_m, 0);
    chk("rst_frame_done", frame_done_m, 0);
    rst_n      = 1'b1;
    sout_ready = 1'b1;
    chk("in_ready_after_rst", in_ready_m, 1);

    // A5 MSB-first with free-running consumer
    send(8'hA5);
    for (int c = 0; c < 8; c++) begin
      chk("a5_bit",   sout_m,       seq_a5[c]);
      chk("a5_valid", sout_valid_m, 1);
      @(negedge clk);
    end
    repeat (FL - W) @(negedge clk);
    chk("a5_frame_done", frame_done_m, 1);
    chk("a5_idle",       sout_valid_m, 0);
    @(negedge clk);
    chk("a5_done_pulse", frame_done_m, 0);
    drain();

    // 01 LSB-first: single leading one
    send(8'h01);
    for (int c = 0; c < 8; c++) begin
      chk("lsb01_bit", sout_l, (c == 0) ? 1 : 0);
      @(negedge clk);
    end
    drain();

    // C3 with a three-cycle stall on bit index 2
    send(8'hC3);
    chk("c3_bit0", sout_m, 1);
    @(negedge clk);
    chk("c3_bit1", sout_m, 1);
    @(negedge clk);
    chk("c3_bit2", sout_m, 0);
    sout_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("c3_hold_bit",   sout_m,       0);
      chk("c3_hold_valid", sout_valid_m, 1);
    end
    sout_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("c3_bit6", sout_m, 1);
    @(negedge clk);
    chk("c3_bit7", sout_m, 1);
    drain();

    // Back-to-back FF then 00 with in_valid held high
    in_data  = 8'hFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'h00;
    for (int c = 1; c <= int'(2 * FL); c++) begin
      chk("b2b_valid", sout_valid_m, 1);
      chk("b2b_bit",   sout_m,       (c <= int'(W)) ? 1 : 0);
      if (c < int'(FL))  chk("b2b_in_ready_low",  in_ready_m, 0);
      if (c == int'(FL)) chk("b2b_in_ready_high", in_ready_m, 1);
      if (c == int'(FL) + 1) in_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_end_valid", sout_valid_m, 0);
    chk("b2b_end_done",  frame_done_m, 1);
    drain();

    // Asynchronous reset in the middle of a frame
    send(8'h08);
    repeat (4) @(negedge clk);
    chk("rst_mid_bit4",  sout_m,       1);
    chk("rst_mid_valid", sout_valid_m, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_sout",    sout_m,       0);
    chk("async_rst_valid_m", sout_valid_m, 0);
    chk("async_rst_valid_l", sout_valid_l, 0);
    chk("async_rst_done",    frame_done_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_in_ready", in_ready_m, 1);
    send(8'h3C);
    for (int c = 0; c < 8; c++) begin
      chk("3c_bit_m", sout_m, seq_3c[c]);
      chk("3c_bit_l", sout_l, seq_3c[c]);
      @(negedge clk);
    end
    drain();

`ifdef PISO_PARITY_EN
    // Even-parity bit after the data bits
    send(8'h07);
    repeat (8) @(negedge clk);
    chk("par07_m", sout_m, 1);
    chk("par07_l", sout_l, 1);
    drain();
    send(8'h03);
    repeat (8) @(negedge clk);
    chk("par03_m", sout_m, 0);
    chk("par03_l", sout_l, 0);
    drain();
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
